// File: rtl/alu_pkg.sv
// Shared encodings for the ALU, its control decoder and the execute stage.
package alu_pkg;

   // 4-bit ALU operation selects driven on alu_control
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // Coarse operation class produced by the main decoder
   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_RTYPE  = 2'b10,
      ALUOP_RSVD   = 2'b11
   } aluop_e;

   // funct3 values recognised for R-type operations
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational XLEN-bit ALU: AND, OR, ADD, SUB with a zero flag.
module alu
   import alu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      alu_control,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   // Operation select; unknown controls yield zero so the output is never X
   always_comb begin
      result = '0;
      case (alu_control)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_ctrl_decode.sv
// Maps aluop/funct fields to an ALU control code; flags unsupported encodings.
// Purely combinational so hazard/forwarding logic can reuse it.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7_b30,
   output logic [3:0] alu_control,
   output logic       illegal
);

   // Decode table; anything not listed is illegal and drives control 0000
   always_comb begin
      alu_control = ALU_AND;
      illegal     = 1'b0;
      case (aluop)
         ALUOP_MEM:    alu_control = ALU_ADD;
         ALUOP_BRANCH: alu_control = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct3)
               F3_ADD_SUB: alu_control = funct7_b30 ? ALU_SUB : ALU_ADD;
               F3_AND:     alu_control = ALU_AND;
               F3_OR:      alu_control = ALU_OR;
               default:    illegal     = 1'b1;
            endcase
         end
         default:      illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline around the ALU with valid/ready on both sides.
// S1 holds decoded operands, S2 (the out_* registers) holds the ALU result.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_aluop,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7_b30,
   input  logic              in_alu_src,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [REG_AW-1:0] in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic              out_zero,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_illegal
);

   logic [3:0]        dec_control;
   logic              dec_illegal;
   logic              s1_valid_reg;
   logic [3:0]        s1_control_reg;
   logic [XLEN-1:0]   s1_a_reg;
   logic [XLEN-1:0]   s1_b_reg;
   logic [REG_AW-1:0] s1_rd_reg;
   logic              s1_illegal_reg;
   logic [XLEN-1:0]   alu_result;
   logic              alu_zero;
   logic              out_valid_reg;
   logic [XLEN-1:0]   out_result_reg;
   logic              out_zero_reg;
   logic [REG_AW-1:0] out_rd_reg;
   logic              out_illegal_reg;
   logic              s2_free;
   logic              s1_advance;
   logic              accept;

   alu_ctrl_decode u_decode (
      .aluop       (in_aluop),
      .funct3      (in_funct3),
      .funct7_b30  (in_funct7_b30),
      .alu_control (dec_control),
      .illegal     (dec_illegal)
   );

   // S2 can take a new result if empty or if it is handing off this cycle;
   // this lets drain, advance and fill all happen together without a bubble.
   assign s2_free    = !out_valid_reg || out_ready;
   assign s1_advance = s1_valid_reg && s2_free && !flush;
   assign in_ready   = !flush && (!s1_valid_reg || s2_free);
   assign accept     = in_valid && in_ready;

   // S1: capture decoded control and selected operands on an accepted input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg   <= 1'b0;
         s1_control_reg <= '0;
         s1_a_reg       <= '0;
         s1_b_reg       <= '0;
         s1_rd_reg      <= '0;
         s1_illegal_reg <= 1'b0;
      end else if (flush) begin
         s1_valid_reg <= 1'b0;
      end else if (accept) begin
         s1_valid_reg   <= 1'b1;
         s1_control_reg <= dec_control;
         s1_a_reg       <= in_rs1_data;
         s1_b_reg       <= in_alu_src ? in_imm : in_rs2_data;
         s1_rd_reg      <= in_rd;
         s1_illegal_reg <= dec_illegal;
      end else if (s1_advance) begin
         s1_valid_reg <= 1'b0;
      end
   end

   alu #(.XLEN(XLEN)) u_alu (
      .a           (s1_a_reg),
      .b           (s1_b_reg),
      .alu_control (s1_control_reg),
      .result      (alu_result),
      .zero        (alu_zero)
   );

   // S2: register the ALU result; illegal ops report a forced zero result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg   <= 1'b0;
         out_result_reg  <= '0;
         out_zero_reg    <= 1'b0;
         out_rd_reg      <= '0;
         out_illegal_reg <= 1'b0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
      end else if (s1_advance) begin
         out_valid_reg   <= 1'b1;
         out_result_reg  <= s1_illegal_reg ? '0 : alu_result;
         out_zero_reg    <= s1_illegal_reg ? 1'b1 : alu_zero;
         out_rd_reg      <= s1_rd_reg;
         out_illegal_reg <= s1_illegal_reg;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid   = out_valid_reg;
   assign out_result  = out_result_reg;
   assign out_zero    = out_zero_reg;
   assign out_rd      = out_rd_reg;
   assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with a queue-based scoreboard.
module tb_alu_exec_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_aluop;
   logic [2:0]  in_funct3;
   logic        in_funct7_b30;
   logic        in_alu_src;
   logic [63:0] in_rs1_data;
   logic [63:0] in_rs2_data;
   logic [63:0] in_imm;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic        out_zero;
   logic [4:0]  out_rd;
   logic        out_illegal;

   typedef struct packed {
      logic [63:0] result;
      logic        zero;
      logic [4:0]  rd;
      logic        illegal;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   alu_exec_stage #(.XLEN(64), .REG_AW(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_aluop      (in_aluop),
      .in_funct3     (in_funct3),
      .in_funct7_b30 (in_funct7_b30),
      .in_alu_src    (in_alu_src),
      .in_rs1_data   (in_rs1_data),
      .in_rs2_data   (in_rs2_data),
      .in_imm        (in_imm),
      .in_rd         (in_rd),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_zero      (out_zero),
      .out_rd        (out_rd),
      .out_illegal   (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [1:0] aluop, input logic [2:0] f3, input logic b30,
                         input logic src, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm, input logic [4:0] rd);
      in_aluop      = aluop;
      in_funct3     = f3;
      in_funct7_b30 = b30;
      in_alu_src    = src;
      in_rs1_data   = a;
      in_rs2_data   = b;
      in_imm        = imm;
      in_rd         = rd;
      in_valid      = 1'b1;
   endtask

   // Wait for the handshake; the expected response is queued just before the capturing edge
   task automatic wait_accept(input logic push, input logic [63:0] er, input logic ez,
                              input logic eil, output int waits);
      bit done;
      exp_t e;
      waits = 0;
      done  = 0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
         end else begin
            waits++;
            if (waits >= 50) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: rd=%0d not accepted after %0d cycles", in_rd, waits);
               in_valid = 1'b0;
               return;
            end
         end
      end
      if (push) begin
         e.result  = er;
         e.zero    = ez;
         e.rd      = in_rd;
         e.illegal = eil;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic issue(input logic [1:0] aluop, input logic [2:0] f3, input logic b30,
                        input logic src, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [4:0] rd, input logic push,
                        input logic [63:0] er, input logic ez, input logic eil,
                        output int waits);
      set_op(aluop, f3, b30, src, a, b, imm, rd);
      wait_accept(push, er, ez, eil, waits);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results still outstanding, expected 0", sb.size());
      end
      sync();
   endtask

   // Monitor: pop and compare whenever the DUT hands a result downstream
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: rd=%0d result=0x%0h, expected no output", out_rd, out_result);
            end else begin
               e = sb.pop_front();
               if (out_result !== e.result || out_zero !== e.zero ||
                   out_rd !== e.rd || out_illegal !== e.illegal) begin
                  errors++;
                  $display("FAIL result: got rd=%0d res=0x%0h z=%0b ill=%0b, expected rd=%0d res=0x%0h z=%0b ill=%0b",
                           out_rd, out_result, out_zero, out_illegal, e.rd, e.result, e.zero, e.illegal);
               end else begin
                  $display("result rd=%0d res=0x%0h zero=%0b illegal=%0b ok", out_rd, out_result, out_zero, out_illegal);
               end
            end
         end
      end
   end

   initial begin
      int w1, w2;
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 5'd0);
      in_valid = 1'b0;

      // Reset state
      #3;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
      chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
      chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // R-type AND and its latency
      sync();
      issue(2'b10, 3'b111, 1'b0, 1'b0, 64'hB, 64'hD, 64'h0, 5'd1, 1'b1, 64'h9, 1'b0, 1'b0, w1);
      @(negedge clk);
      chk("and_lat_s1", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("and_lat_s2", {63'd0, out_valid}, 64'd1);

      // OR then ADD back to back
      sync();
      issue(2'b10, 3'b110, 1'b0, 1'b0, 64'h9, 64'hC, 64'h0, 5'd2, 1'b1, 64'hD, 1'b0, 1'b0, w1);
      issue(2'b10, 3'b000, 1'b0, 1'b0, 64'h6, 64'h5, 64'h0, 5'd3, 1'b1, 64'hB, 1'b0, 1'b0, w2);
      chk("b2b_wait_op1", 64'(w1), 64'd0);
      chk("b2b_wait_op2", 64'(w2), 64'd0);
      @(negedge clk);
      chk("b2b_first_rd", {59'd0, out_rd}, 64'd2);
      @(negedge clk);
      chk("b2b_second_rd", {59'd0, out_rd}, 64'd3);
      chk("b2b_second_valid", {63'd0, out_valid}, 64'd1);

      // SUB zero, R-type SUB, immediate ADD, illegal, reserved aluop, wrap
      sync();
      issue(2'b01, 3'b000, 1'b0, 1'b0, 64'h7, 64'h7, 64'h0, 5'd4, 1'b1, 64'h0, 1'b1, 1'b0, w1);
      issue(2'b10, 3'b000, 1'b1, 1'b0, 64'h7, 64'h3, 64'h0, 5'd5, 1'b1, 64'h4, 1'b0, 1'b0, w1);
      issue(2'b00, 3'b000, 1'b0, 1'b1, 64'hB, 64'h55, 64'h4, 5'd6, 1'b1, 64'hF, 1'b0, 1'b0, w1);
      issue(2'b10, 3'b100, 1'b0, 1'b0, 64'h5, 64'h3, 64'h0, 5'd7, 1'b1, 64'h0, 1'b1, 1'b1, w1);
      issue(2'b11, 3'b000, 1'b0, 1'b0, 64'h1, 64'h1, 64'h0, 5'd8, 1'b1, 64'h0, 1'b1, 1'b1, w1);
      issue(2'b00, 3'b000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 5'd9, 1'b1, 64'h0, 1'b1, 1'b0, w1);
      wait_drain();

      // Back-pressure: two ops fill the pipe, the third stalls, outputs hold
      out_ready = 1'b0;
      issue(2'b10, 3'b111, 1'b0, 1'b0, 64'hF0, 64'h3C, 64'h0, 5'd10, 1'b1, 64'h30, 1'b0, 1'b0, w1);
      issue(2'b10, 3'b110, 1'b0, 1'b0, 64'h1, 64'h2, 64'h0, 5'd11, 1'b1, 64'h3, 1'b0, 1'b0, w2);
      chk("bp_wait_op1", 64'(w1), 64'd0);
      chk("bp_wait_op2", 64'(w2), 64'd0);
      set_op(2'b00, 3'b000, 1'b0, 1'b0, 64'h10, 64'h20, 64'h0, 5'd12);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_hold_rd", {59'd0, out_rd}, 64'd10);
         chk("bp_hold_result", out_result, 64'h30);
      end
      sync();
      out_ready = 1'b1;
      wait_accept(1'b1, 64'h30, 1'b0, 1'b0, w1);
      wait_drain();

      // Flush with both stages full drops everything
      out_ready = 1'b0;
      issue(2'b00, 3'b000, 1'b0, 1'b0, 64'h1, 64'h2, 64'h0, 5'd13, 1'b0, 64'h0, 1'b0, 1'b0, w1);
      issue(2'b00, 3'b000, 1'b0, 1'b0, 64'h3, 64'h4, 64'h0, 5'd14, 1'b0, 64'h0, 1'b0, 1'b0, w1);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
      sync();
      flush = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_no_valid", {63'd0, out_valid}, 64'd0);
      end
      chk("flush_in_ready_after", {63'd0, in_ready}, 64'd1);

      // Asynchronous reset during a stall clears outputs before any edge
      sync();
      out_ready = 1'b0;
      issue(2'b00, 3'b000, 1'b0, 1'b0, 64'h1, 64'h1, 64'h0, 5'd15, 1'b0, 64'h0, 1'b0, 1'b0, w1);
      issue(2'b00, 3'b000, 1'b0, 1'b0, 64'h2, 64'h2, 64'h0, 5'd16, 1'b0, 64'h0, 1'b0, 1'b0, w1);
      @(negedge clk);
      chk("prerst_valid", {63'd0, out_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_result", out_result, 64'd0);
      chk("arst_rd", {59'd0, out_rd}, 64'd0);
      chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("postrst_no_valid", {63'd0, out_valid}, 64'd0);
      end

      // Pipe works again after reset
      sync();
      issue(2'b00, 3'b000, 1'b0, 1'b0, 64'h2, 64'h3, 64'h0, 5'd17, 1'b1, 64'h5, 1'b0, 1'b0, w1);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
